// File: rtl/sample_capture.sv
// Logic-analyser acquisition front end: 2-flop channel sync, programmable decimation,
// wide/narrow word packing and FIFO write strobe with sticky overrun on a dropped word.
module sample_capture #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      chan_in,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  input  logic             narrow,
  input  logic             fifo_full,
  output logic [15:0]      sample_data,
  output logic             sample_data_avail,
  output logic             running,
  output logic             overrun,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, RUN, OVR} state_t;

  state_t           state_q, state_d;
  logic [15:0]      s1_q, s1_d, s2_q, s2_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             narrow_q, narrow_d, half_q, half_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      data_q, data_d;
  logic             avail_q, avail_d, running_q, running_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] wc_q, wc_d;

  logic             tick, word_rdy;
  logic [15:0]      word;

  assign tick     = (state_q == RUN) && (cnt_q == '0);
  assign word     = narrow_q ? {s2_q[7:0], lo_q} : s2_q;
  assign word_rdy = tick && (!narrow_q || half_q);

  always_comb begin
    state_d   = state_q;
    s1_d      = chan_in;
    s2_d      = s1_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    narrow_d  = narrow_q;
    half_d    = half_q;
    lo_d      = lo_q;
    data_d    = data_q;
    avail_d   = 1'b0;
    ovr_d     = ovr_q;
    wc_d      = wc_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = RUN;
          div_d    = divider;
          narrow_d = narrow;
          cnt_d    = '0;
          half_d   = 1'b0;
          wc_d     = '0;
          ovr_d    = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          // Stopping wins over any write or drop on the same edge
          state_d = IDLE;
          half_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = tick ? div_q : cnt_q - 1'b1;
          if (tick && narrow_q && !half_q) begin
            lo_d   = s2_q[7:0];
            half_d = 1'b1;
          end
          if (word_rdy) begin
            half_d = 1'b0;
            if (fifo_full) begin
              ovr_d   = 1'b1;
              state_d = OVR;
            end else begin
              data_d  = word;
              avail_d = 1'b1;
              wc_d    = (&wc_q) ? wc_q : wc_q + 1'b1;
            end
          end
        end
      end
      OVR: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      narrow_q  <= 1'b0;
      half_q    <= 1'b0;
      lo_q      <= '0;
      data_q    <= '0;
      avail_q   <= 1'b0;
      running_q <= 1'b0;
      ovr_q     <= 1'b0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      narrow_q  <= narrow_d;
      half_q    <= half_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      avail_q   <= avail_d;
      running_q <= running_d;
      ovr_q     <= ovr_d;
      wc_q      <= wc_d;
    end
  end

  assign sample_data       = data_q;
  assign sample_data_avail = avail_q;
  assign running           = running_q;
  assign overrun           = ovr_q;
  assign word_count        = wc_q;

endmodule
